// File: rtl/oldland_operand_fwd.sv
// Operand forwarding and load-use interlock for the oldland pipeline.
// Optional statistics counters are enabled by defining OLDLAND_FWD_STATS_EN.
module oldland_operand_fwd #(
  parameter int NUM_PORTS  = 2,
  parameter int NUM_STAGES = 2,
  parameter int SEL_BITS   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LOAD_STAGE = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             advance,
  input  logic                             flush,
  input  logic [NUM_PORTS*SEL_BITS-1:0]    src_sel,
  input  logic [NUM_PORTS-1:0]             src_used,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  rf_val,
  input  logic [NUM_STAGES*SEL_BITS-1:0]   st_rd_sel,
  input  logic [NUM_STAGES-1:0]            st_update_rd,
  input  logic [NUM_STAGES-1:0]            st_is_load,
  input  logic [NUM_STAGES*DATA_WIDTH-1:0] st_result,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]  op_val,
  output logic                             stall
`ifdef OLDLAND_FWD_STATS_EN
  ,
  input  logic                             stat_clr,
  output logic [31:0]                      stat_fwd_cnt,
  output logic [31:0]                      stat_stall_cnt
`endif
);

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  logic [NUM_PORTS-1:0] hit_vld;
  logic [NUM_PORTS-1:0] hit_load;
  logic [IDX_W-1:0]     hit_idx [NUM_PORTS];

  logic [NUM_PORTS-1:0] sel_vld_d, sel_vld_q;
  logic [IDX_W-1:0]     sel_idx_d [NUM_PORTS];
  logic [IDX_W-1:0]     sel_idx_q [NUM_PORTS];

  // Scan stages oldest-first so the youngest matching producer overwrites the result.
  always_comb begin
    hit_vld  = '0;
    hit_load = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      hit_idx[p] = '0;
      for (int k = NUM_STAGES - 1; k >= 0; k--) begin
        if (src_used[p] && st_update_rd[k] &&
            (st_rd_sel[k*SEL_BITS +: SEL_BITS] == src_sel[p*SEL_BITS +: SEL_BITS])) begin
          hit_vld[p]  = 1'b1;
          hit_idx[p]  = IDX_W'(k);
          hit_load[p] = st_is_load[k] && (k < LOAD_STAGE);
        end
      end
    end
  end

  assign stall = (|hit_load) && !flush;

  always_comb begin
    sel_vld_d = sel_vld_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      sel_idx_d[p] = sel_idx_q[p];
    end
    if (flush) begin
      sel_vld_d = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        sel_idx_d[p] = '0;
      end
    end else if (advance && !stall) begin
      sel_vld_d = hit_vld;
      for (int p = 0; p < NUM_PORTS; p++) begin
        sel_idx_d[p] = hit_idx[p];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_vld_q <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        sel_idx_q[p] <= '0;
      end
    end else begin
      sel_vld_q <= sel_vld_d;
      for (int p = 0; p < NUM_PORTS; p++) begin
        sel_idx_q[p] <= sel_idx_d[p];
      end
    end
  end

  // The operand mux adds no latency: the execute stage sees the live stage result.
  always_comb begin
    op_val = rf_val;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (sel_vld_q[p] && (sel_idx_q[p] == IDX_W'(k))) begin
          op_val[p*DATA_WIDTH +: DATA_WIDTH] = st_result[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

`ifdef OLDLAND_FWD_STATS_EN
  logic [31:0] stat_fwd_cnt_d, stat_fwd_cnt_q;
  logic [31:0] stat_stall_cnt_d, stat_stall_cnt_q;
  logic [32:0] fwd_inc;
  logic [32:0] fwd_sum;

  // Counts forwards that are actually committed into the select registers.
  always_comb begin
    fwd_inc = '0;
    if (advance && !stall && !flush) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        fwd_inc = fwd_inc + {32'd0, hit_vld[p]};
      end
    end
    fwd_sum          = {1'b0, stat_fwd_cnt_q} + fwd_inc;
    stat_fwd_cnt_d   = fwd_sum[32] ? 32'hFFFF_FFFF : fwd_sum[31:0];
    stat_stall_cnt_d = stat_stall_cnt_q;
    if (stall && (stat_stall_cnt_q != 32'hFFFF_FFFF)) begin
      stat_stall_cnt_d = stat_stall_cnt_q + 32'd1;
    end
    if (stat_clr) begin
      stat_fwd_cnt_d   = '0;
      stat_stall_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_fwd_cnt_q   <= '0;
      stat_stall_cnt_q <= '0;
    end else begin
      stat_fwd_cnt_q   <= stat_fwd_cnt_d;
      stat_stall_cnt_q <= stat_stall_cnt_d;
    end
  end

  assign stat_fwd_cnt   = stat_fwd_cnt_q;
  assign stat_stall_cnt = stat_stall_cnt_q;
`endif

endmodule

// File: tb/tb_oldland_operand_fwd.sv
// Directed testbench for oldland_operand_fwd with default parameters.
module tb_oldland_operand_fwd;

  logic        clk;
  logic        rst_n;
  logic        advance;
  logic        flush;
  logic [7:0]  src_sel;
  logic [1:0]  src_used;
  logic [63:0] rf_val;
  logic [7:0]  st_rd_sel;
  logic [1:0]  st_update_rd;
  logic [1:0]  st_is_load;
  logic [63:0] st_result;
  logic [63:0] op_val;
  logic        stall;
`ifdef OLDLAND_FWD_STATS_EN
  logic        stat_clr;
  logic [31:0] stat_fwd_cnt;
  logic [31:0] stat_stall_cnt;
`endif

  int checks;
  int errors;

  oldland_operand_fwd dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .advance      (advance),
    .flush        (flush),
    .src_sel      (src_sel),
    .src_used     (src_used),
    .rf_val       (rf_val),
    .st_rd_sel    (st_rd_sel),
    .st_update_rd (st_update_rd),
    .st_is_load   (st_is_load),
    .st_result    (st_result),
    .op_val       (op_val),
    .stall        (stall)
`ifdef OLDLAND_FWD_STATS_EN
    ,
    .stat_clr       (stat_clr),
    .stat_fwd_cnt   (stat_fwd_cnt),
    .stat_stall_cnt (stat_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    advance      = 1'b0;
    flush        = 1'b0;
    src_sel      = 8'h00;
    src_used     = 2'b00;
    st_rd_sel    = 8'h00;
    st_update_rd = 2'b00;
    st_is_load   = 2'b00;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    idle_inputs();
    rf_val    = {32'h2222_2222, 32'h1111_1111};
    st_result = {32'h9999_9999, 32'h8888_8888};
`ifdef OLDLAND_FWD_STATS_EN
    stat_clr  = 1'b0;
`endif
    #12;
    checks++;
    if (op_val !== 64'h2222_2222_1111_1111) begin
      errors++;
      $display("[TB] FAIL reset_op_val: got %h expected %h", op_val, 64'h2222_2222_1111_1111);
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_stall: got %b expected 0", stall);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_alu_forward();
    idle_inputs();
    st_rd_sel    = 8'h03;
    st_update_rd = 2'b01;
    src_sel      = 8'h03;
    src_used     = 2'b01;
    advance      = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL alu_stall: got %b expected 0", stall);
    end
    step();
    idle_inputs();
    st_result = {32'h0000_5555, 32'h0000_1234};
    rf_val    = {32'h2222_2222, 32'hFFFF_FFFF};
    #1;
    checks++;
    if (op_val[31:0] !== 32'h0000_1234) begin
      errors++;
      $display("[TB] FAIL alu_fwd_p0: got %h expected %h", op_val[31:0], 32'h0000_1234);
    end
    checks++;
    if (op_val[63:32] !== 32'h2222_2222) begin
      errors++;
      $display("[TB] FAIL alu_p1_regfile: got %h expected %h", op_val[63:32], 32'h2222_2222);
    end
    st_result[31:0] = 32'h0000_4321;
    #1;
    checks++;
    if (op_val[31:0] !== 32'h0000_4321) begin
      errors++;
      $display("[TB] FAIL alu_fwd_live: got %h expected %h", op_val[31:0], 32'h0000_4321);
    end
  endtask

  task automatic test_priority();
    idle_inputs();
    st_rd_sel    = 8'h55;
    st_update_rd = 2'b11;
    src_sel      = 8'h50;
    src_used     = 2'b10;
    advance      = 1'b1;
    step();
    idle_inputs();
    st_result = {32'h0000_000B, 32'h0000_000A};
    rf_val    = {32'h3333_3333, 32'h4444_4444};
    #1;
    checks++;
    if (op_val[63:32] !== 32'h0000_000A) begin
      errors++;
      $display("[TB] FAIL priority_p1: got %h expected %h", op_val[63:32], 32'h0000_000A);
    end
    checks++;
    if (op_val[31:0] !== 32'h4444_4444) begin
      errors++;
      $display("[TB] FAIL priority_p0_none: got %h expected %h", op_val[31:0], 32'h4444_4444);
    end
    st_rd_sel    = 8'h61;
    st_update_rd = 2'b10;
    src_sel      = 8'h06;
    src_used     = 2'b01;
    advance      = 1'b1;
    step();
    idle_inputs();
    st_result = {32'h0000_0066, 32'h0000_0011};
    #1;
    checks++;
    if (op_val[31:0] !== 32'h0000_0066) begin
      errors++;
      $display("[TB] FAIL stage1_fwd_p0: got %h expected %h", op_val[31:0], 32'h0000_0066);
    end
  endtask

  task automatic test_load_use();
    idle_inputs();
    st_rd_sel    = 8'h90;
    st_update_rd = 2'b10;
    src_sel      = 8'h09;
    src_used     = 2'b01;
    advance      = 1'b1;
    step();
    st_rd_sel    = 8'h02;
    st_update_rd = 2'b01;
    st_is_load   = 2'b01;
    src_sel      = 8'h02;
    src_used     = 2'b01;
    advance      = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("[TB] FAIL load_use_stall: got %b expected 1", stall);
    end
    step();
    st_rd_sel    = 8'h20;
    st_update_rd = 2'b10;
    st_is_load   = 2'b10;
    st_result    = {32'h0000_5555, 32'h0000_7777};
    #1;
    checks++;
    if (op_val[31:0] !== 32'h0000_5555) begin
      errors++;
      $display("[TB] FAIL load_use_hold: got %h expected %h", op_val[31:0], 32'h0000_5555);
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL load_use_release: got %b expected 0", stall);
    end
    step();
    idle_inputs();
    st_result = {32'h0000_CAFE, 32'h0000_7777};
    #1;
    checks++;
    if (op_val[31:0] !== 32'h0000_CAFE) begin
      errors++;
      $display("[TB] FAIL load_use_fwd: got %h expected %h", op_val[31:0], 32'h0000_CAFE);
    end
  endtask

  task automatic test_no_match();
    idle_inputs();
    st_rd_sel    = 8'h21;
    st_update_rd = 2'b11;
    src_sel      = 8'h77;
    src_used     = 2'b11;
    advance      = 1'b1;
    step();
    idle_inputs();
    rf_val    = {32'h0000_BEEF, 32'h0000_DEAD};
    st_result = {32'h1111_0000, 32'h2222_0000};
    #1;
    checks++;
    if (op_val !== 64'h0000_BEEF_0000_DEAD) begin
      errors++;
      $display("[TB] FAIL no_match: got %h expected %h", op_val, 64'h0000_BEEF_0000_DEAD);
    end
    st_rd_sel    = 8'h04;
    st_update_rd = 2'b01;
    st_is_load   = 2'b01;
    src_sel      = 8'h84;
    src_used     = 2'b10;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL unused_port_stall: got %b expected 0", stall);
    end
    src_used = 2'b01;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("[TB] FAIL used_port_stall: got %b expected 1", stall);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_flush();
    idle_inputs();
    st_rd_sel    = 8'h0A;
    st_update_rd = 2'b01;
    src_sel      = 8'h0A;
    src_used     = 2'b01;
    advance      = 1'b1;
    step();
    st_is_load = 2'b01;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_pre_stall: got %b expected 1", stall);
    end
    flush = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_stall: got %b expected 0", stall);
    end
    step();
    idle_inputs();
    rf_val    = {32'h0000_00F1, 32'h0000_00F0};
    st_result = {32'h0000_0BAD, 32'h0000_0BAD};
    #1;
    checks++;
    if (op_val !== 64'h0000_00F1_0000_00F0) begin
      errors++;
      $display("[TB] FAIL flush_selects: got %h expected %h", op_val, 64'h0000_00F1_0000_00F0);
    end
  endtask

  task automatic test_async_reset();
    idle_inputs();
    st_rd_sel    = 8'h60;
    st_update_rd = 2'b10;
    src_sel      = 8'h66;
    src_used     = 2'b11;
    advance      = 1'b1;
    step();
    idle_inputs();
    st_result = {32'h0000_AAAA, 32'h0000_BBBB};
    rf_val    = {32'h0000_0001, 32'h0000_0002};
    #1;
    checks++;
    if (op_val !== 64'h0000_AAAA_0000_AAAA) begin
      errors++;
      $display("[TB] FAIL pre_reset_fwd: got %h expected %h", op_val, 64'h0000_AAAA_0000_AAAA);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (op_val !== 64'h0000_0001_0000_0002) begin
      errors++;
      $display("[TB] FAIL async_reset_op_val: got %h expected %h", op_val, 64'h0000_0001_0000_0002);
    end
`ifdef OLDLAND_FWD_STATS_EN
    checks++;
    if ((stat_fwd_cnt !== 32'd0) || (stat_stall_cnt !== 32'd0)) begin
      errors++;
      $display("[TB] FAIL async_reset_stats: got %h/%h expected 0/0", stat_fwd_cnt, stat_stall_cnt);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (op_val !== 64'h0000_0001_0000_0002) begin
      errors++;
      $display("[TB] FAIL post_reset_op_val: got %h expected %h", op_val, 64'h0000_0001_0000_0002);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_alu_forward();
    test_priority();
    test_load_use();
    test_no_match();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
